hamming_frame_decoder: RTL
==========================

# hamming_frame_decoder

Receive side of the Hamming(7,4) serial link. Hunts the incoming bitstream for the 8-bit frame header and collects the 56-bit payload of eight codewords. Corrects up to one bit error per codeword, then serializes the recovered 32-bit word MSB-first through a ready/valid output. It sits directly downstream of the link's encoder/transmitter, on a single clock domain.

## Interface
- `HDR_NORMAL`, default 8'h7E: header marking an ordinary frame.
- `HDR_FIRST`, default 8'h6E: header marking the first frame of a stream.
- `clk_in` input 1: the only clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `data_in` input 1: line bit, sampled when `data_in_valid` is high.
- `data_in_valid` input 1: qualifies `data_in` for one cycle per bit.
- `data_out` input-side output 1: current decoded bit, MSB of the word first.
- `data_out_valid` output 1: `data_out` is valid.
- `data_out_ready` input 1: downstream accepts the bit when high together with valid.
- `frame_sync` output 1: high while payload bits are being collected.
- `frame_done` output 1: one-cycle pulse when a frame has been decoded.
- `first_frame` output 1: valid with `frame_done`; set when the header was `HDR_FIRST`.
- `corr_count` output 4: valid with `frame_done`; number of codewords corrected (0..8).
- `overflow` output 1: one-cycle pulse when a decoded frame is dropped.

## Operation
- Frame on the line is 64 bits, MSB first:
  - bits 63:56 are the header;
  - bits 55:49 are codeword 7, carrying data[31:28];
  - continuing down to bits 6:0, codeword 0, carrying data[3:0].
- Codeword layout, cw[6:0] = {d3,d2,d1,p4,d0,p2,p1}:
  - p1 = d0^d1^d3;
  - p2 = d0^d2^d3;
  - p4 = d1^d2^d3.
- Syndrome:
  - s = {cw6^cw5^cw4^cw3, cw6^cw5^cw2^cw1, cw6^cw4^cw2^cw0};
  - s≠0 means flip cw[s-1] and count that codeword as corrected;
  - double errors are miscorrected silently, with no detection.
- FSM states: HUNT, PAYLOAD, DECODE.
  - HUNT: each valid bit shifts into the 8-bit `hdr_sr`. If the shifted value equals `HDR_NORMAL` or `HDR_FIRST`, latch `first_frame` (set only for `HDR_FIRST`), clear the bit counter and go to PAYLOAD.
  - PAYLOAD: each valid bit shifts into the 56-bit payload register and the 6-bit counter increments. On the 56th bit (counter==55 with valid), go to DECODE. `hdr_sr` is cleared on entry.
  - DECODE: lasts exactly one cycle. Eight correctors run in parallel, `frame_done` pulses and `corr_count` is driven, and the FSM returns to HUNT. A valid bit arriving in this cycle is shifted into `hdr_sr` and is not lost, so back-to-back frames are received.
- Output serializer:
  - holds a 32-bit buffer and a 6-bit `remaining` count;
  - `data_out_valid` = (`remaining`≠0) and `data_out` = buf[31];
  - on each valid&&ready, shift the buffer left by one and decrement `remaining`.
- Load rule in DECODE:
  - load the buffer with `remaining`=32 if `remaining`==0, or if `remaining`==1 and a handshake occurs in the same cycle;
  - otherwise the frame is dropped and `overflow` pulses. `frame_done` still pulses.

## Timing
- Reset: every output is 0, the FSM is in HUNT, and `hdr_sr`, the payload register, the counter and the serializer are cleared. Reset mid-frame discards the partial frame.
- Header match is registered. `frame_sync` rises the cycle after the 8th header bit is sampled.
- Latency: the last payload bit is sampled in cycle T, DECODE is T+1, and `data_out_valid` rises at T+2 with data[31].
- `frame_sync` falls at T+1.
- Sustained rate: at most one output bit per cycle. Meeting the rate needs `data_out_ready` to drain 32 bits before the next frame's DECODE cycle.
- `data_in_valid` low stalls every state except DECODE, which always completes in one cycle.
- While `data_out_valid` is high, `data_out` holds until the handshake completes.

## Structure
- Package `hamming_link_pkg`, shared with the transmitter:
  - `HDR_NORMAL_C` / `HDR_FIRST_C`;
  - `FRAME_BITS`=64, `PAYLOAD_BITS`=56, `N_CW`=8, `CW_BITS`=7;
  - the FSM state enum.
- Sub-module `hamming_cw_corrector`: combinational, 7-bit codeword in, 4-bit data out plus a `corrected` flag. It is instantiated 8 times.
- The top level holds the FSM, the shift registers and the serializer.

## Test plan
- `HDR_NORMAL` + clean encode of 0xDEADBEEF, `data_out_ready`=1:
  - serial out is 0xDEADBEEF, starting 2 cycles after the last payload bit;
  - `corr_count`=0, `first_frame`=0.
- Same frame with the payload bit 20 (cw2, bit 6) flipped, plus a flip in cw7 bit 0: output is still 0xDEADBEEF and `corr_count`=2.
- `HDR_FIRST` frame of 0x12345678, preceded by 13 random bits containing no header:
  - `first_frame`=1, output 0x12345678;
  - no `frame_done` during the garbage bits.
- Two back-to-back frames (0xA5A5A5A5, 0x0F0F0F0F) with `data_out_ready`=0 throughout:
  - the first is held in the buffer;
  - the second's DECODE pulses `overflow` and is dropped;
  - releasing ready yields only 0xA5A5A5A5.
- Assert `rst` after 30 payload bits, then send a clean 0xCAFEF00D frame:
  - all outputs are 0 during reset;
  - only 0xCAFEF00D is output.
- Random gaps in `data_in_valid` and a random `data_out_ready` over 100 frames: every word matches the reference model in order, and `overflow` never asserts when ready is 1 at least 50% of the time.

Source files
------------

// File: rtl/hamming_link_pkg.sv
// Constants and types shared by the Hamming(7,4) link transmitter and receiver.
package hamming_link_pkg;

  localparam logic [7:0] HDR_NORMAL_C = 8'h7E;
  localparam logic [7:0] HDR_FIRST_C  = 8'h6E;

  localparam int unsigned FRAME_BITS   = 64;
  localparam int unsigned PAYLOAD_BITS = 56;
  localparam int unsigned N_CW         = 8;
  localparam int unsigned CW_BITS      = 7;

  typedef enum logic [1:0] {
    HUNT,
    PAYLOAD,
    DECODE
  } rx_state_t;

endpackage

// File: rtl/hamming_cw_corrector.sv
// Single-error-correcting Hamming(7,4) decoder for one codeword {d3,d2,d1,p4,d0,p2,p1}.
module hamming_cw_corrector
  import hamming_link_pkg::*;
(
  input  logic [CW_BITS-1:0] cw,
  output logic [3:0]         data,
  output logic               corrected
);

  logic [2:0]         syn;
  logic [CW_BITS-1:0] flip;
  logic [CW_BITS-1:0] fixed;

  always_comb begin
    syn = {cw[6] ^ cw[5] ^ cw[4] ^ cw[3],
           cw[6] ^ cw[5] ^ cw[2] ^ cw[1],
           cw[6] ^ cw[4] ^ cw[2] ^ cw[0]};
    flip = '0;
    // Syndrome names the 1-based bit position in error.
    if (syn != 3'd0) flip[syn - 3'd1] = 1'b1;
    fixed     = cw ^ flip;
    data      = {fixed[6], fixed[5], fixed[4], fixed[2]};
    corrected = (syn != 3'd0);
  end

endmodule

// File: rtl/hamming_frame_decoder.sv
// Hamming(7,4) frame receiver: header hunt, 56-bit payload capture, parallel
// correction of eight codewords and MSB-first ready/valid serialization.
module hamming_frame_decoder
  import hamming_link_pkg::*;
#(
  parameter logic [7:0] HDR_NORMAL = HDR_NORMAL_C,
  parameter logic [7:0] HDR_FIRST  = HDR_FIRST_C
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       data_in,
  input  logic       data_in_valid,
  output logic       data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_sync,
  output logic       frame_done,
  output logic       first_frame,
  output logic [3:0] corr_count,
  output logic       overflow
);

  rx_state_t               state_q, state_d;
  logic [7:0]              hdr_sr_q;
  logic [7:0]              hdr_shift;
  logic [PAYLOAD_BITS-1:0] pay_q;
  logic [5:0]              cnt_q;
  logic                    first_q;
  logic [31:0]             buf_q;
  logic [5:0]              rem_q;

  logic [31:0]             dec_data;
  logic [N_CW-1:0]         cw_fix;
  logic [3:0]              n_fix;
  logic                    hdr_hit;
  logic                    hs;
  logic                    load;

  for (genvar g = 0; g < N_CW; g++) begin : g_cw
    hamming_cw_corrector u_cw (
      .cw        (pay_q[g*CW_BITS +: CW_BITS]),
      .data      (dec_data[g*4 +: 4]),
      .corrected (cw_fix[g])
    );
  end

  always_comb begin
    n_fix = '0;
    for (int unsigned i = 0; i < N_CW; i++) n_fix = n_fix + {3'b000, cw_fix[i]};
  end

  assign hdr_shift = {hdr_sr_q[6:0], data_in};
  assign hdr_hit   = (state_q == HUNT) && data_in_valid &&
                     ((hdr_shift == HDR_NORMAL) || (hdr_shift == HDR_FIRST));

  always_ff @(posedge clk_in) begin
    if (rst) state_q <= HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    frame_sync     = 1'b0;
    frame_done     = 1'b0;
    first_frame    = 1'b0;
    corr_count     = '0;
    data_out_valid = (rem_q != 6'd0);
    data_out       = buf_q[31];
    hs             = data_out_valid && data_out_ready;
    load           = 1'b0;
    overflow       = 1'b0;
    case (state_q)
      HUNT: begin
        if (hdr_hit) state_d = PAYLOAD;
      end
      PAYLOAD: begin
        frame_sync = 1'b1;
        if (data_in_valid && (cnt_q == 6'(PAYLOAD_BITS - 1))) state_d = DECODE;
      end
      DECODE: begin
        frame_done  = 1'b1;
        first_frame = first_q;
        corr_count  = n_fix;
        // A word draining its final bit this cycle frees the buffer in time.
        load        = (rem_q == 6'd0) || ((rem_q == 6'd1) && hs);
        overflow    = !load;
        state_d     = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      hdr_sr_q <= '0;
      pay_q    <= '0;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      buf_q    <= '0;
      rem_q    <= '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (data_in_valid) begin
            if (hdr_hit) begin
              hdr_sr_q <= '0;
              cnt_q    <= '0;
              first_q  <= (hdr_shift == HDR_FIRST);
            end else begin
              hdr_sr_q <= hdr_shift;
            end
          end
        end
        PAYLOAD: begin
          if (data_in_valid) begin
            pay_q <= {pay_q[PAYLOAD_BITS-2:0], data_in};
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DECODE: begin
          // First bit of a back-to-back header arrives here.
          if (data_in_valid) hdr_sr_q <= hdr_shift;
        end
        default: ;
      endcase

      if (load) begin
        buf_q <= dec_data;
        rem_q <= 6'd32;
      end else if (hs) begin
        buf_q <= {buf_q[30:0], 1'b0};
        rem_q <= rem_q - 6'd1;
      end
    end
  end

endmodule
